// File: rtl/cpu_pkg.sv
// Shared MIPS32 pipeline definitions used by the fetch and decode stages.
//  ADDR_W          instruction memory word-address width
//  NOP_WORD        bubble word inserted into IF/ID on flush or halt
//  HALT_WORD       fill / end-of-program word; fetching it stops fetch
//  fetch_state_t   fetch FSM states {RUN, HALTED}
package cpu_pkg;

  localparam int          ADDR_W    = 10;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register with hold / load / flush controls.
//  clk, rst        clock and synchronous active-high reset
//  load            capture d_instr / d_pc_plus1 and mark the entry valid
//  flush           replace the entry with a bubble (wins over load)
//  d_instr         incoming instruction word
//  d_pc_plus1      incoming pc+1 (word index, zero-extended)
//  instr           registered instruction to decode
//  pc_plus1        registered pc+1
//  valid           register holds a real instruction
// With neither load nor flush the register holds its contents.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc_plus1,
  output logic [31:0] instr,
  output logic [31:0] pc_plus1,
  output logic        valid
);

  logic [31:0] instr_reg;
  logic [31:0] pc_plus1_reg;
  logic        valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg    <= NOP;
      pc_plus1_reg <= 32'd0;
      valid_reg    <= 1'b0;
    end else if (flush) begin
      // pc_plus1 is meaningless in a bubble, so it is simply left alone.
      instr_reg <= NOP;
      valid_reg <= 1'b0;
    end else if (load) begin
      instr_reg    <= d_instr;
      pc_plus1_reg <= d_pc_plus1;
      valid_reg    <= 1'b1;
    end
  end

  assign instr    = instr_reg;
  assign pc_plus1 = pc_plus1_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS32 instruction fetch front end. Holds the PC, drives the combinational
// instruction memory, captures the returned word into IF/ID, and handles
// stall, branch/jump redirect with flush, halt on the fill word, and a count
// of delivered instructions.
//  clk, rst          clock and synchronous active-high reset
//  stall             hold PC, IF/ID, state and counter this cycle
//  redirect_valid    taken branch / jump; load redirect_target and flush
//  redirect_target   new PC word index
//  imem_addr         {0, pc} to instruction memory
//  imem_instr        word at imem_addr, valid in the same cycle
//  if_id_instr       registered instruction to decode
//  if_id_pc_plus1    registered pc+1 (no wrap, zero-extended)
//  if_id_valid       IF/ID holds a real instruction
//  halted            fetch stopped on HALT_WORD
//  fetch_count       instructions delivered to IF/ID (wraps at 2**32)
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W    = cpu_pkg::ADDR_W,
  parameter int          DEPTH     = 2 ** ADDR_W,
  parameter int          RESET_PC  = 0,
  parameter logic [31:0] HALT_WORD = cpu_pkg::HALT_WORD,
  parameter logic [31:0] NOP_WORD  = cpu_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc_plus1,
  output logic              if_id_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  fetch_state_t      state_reg, state_next;
  logic [31:0]       fetch_count_reg, fetch_count_next;
  logic              if_id_load;
  logic              if_id_flush;
  logic [31:0]       pc_plus1_wide;
  logic [ADDR_W-1:0] pc_wrapped;

  // pc+1 into IF/ID is taken at full width so the last word reports DEPTH,
  // while the PC itself wraps back to word 0.
  assign pc_plus1_wide = 32'(pc_reg) + 32'd1;
  assign pc_wrapped    = (pc_reg == ADDR_W'(DEPTH - 1)) ? '0 : pc_reg + 1'b1;

  // Priority: redirect > stall > HALTED > RUN fetch (rst handled in the flops).
  always_comb begin
    pc_next          = pc_reg;
    state_next       = state_reg;
    fetch_count_next = fetch_count_reg;
    if_id_load       = 1'b0;
    if_id_flush      = 1'b0;
    if (redirect_valid) begin
      pc_next     = redirect_target;
      state_next  = RUN;
      if_id_flush = 1'b1;
    end else if (stall) begin
      // everything holds
    end else if (state_reg == RUN) begin
      if (imem_instr == HALT_WORD) begin
        // Stop on the fill word; the PC stays pointing at it.
        state_next  = HALTED;
        if_id_flush = 1'b1;
      end else begin
        pc_next          = pc_wrapped;
        if_id_load       = 1'b1;
        fetch_count_next = fetch_count_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= ADDR_W'(RESET_PC);
      state_reg       <= RUN;
      fetch_count_reg <= 32'd0;
    end else begin
      pc_reg          <= pc_next;
      state_reg       <= state_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  if_id_reg #(
    .NOP (NOP_WORD)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (if_id_load),
    .flush      (if_id_flush),
    .d_instr    (imem_instr),
    .d_pc_plus1 (pc_plus1_wide),
    .instr      (if_id_instr),
    .pc_plus1   (if_id_pc_plus1),
    .valid      (if_id_valid)
  );

  assign imem_addr   = 32'(pc_reg);
  assign halted      = (state_reg == HALTED);
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by randomized stall / redirect / reset traffic, all compared against a
// cycle-level behavioural model of the fetch rules. A second instance with
// RESET_PC=1023 covers the PC wrap at the top of memory.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [9:0]  redirect_target;
  logic [31:0] imem_addr, imem_instr, if_id_instr, if_id_pc_plus1, fetch_count;
  logic        if_id_valid, halted;

  logic        rst2;
  logic [31:0] imem_addr2, imem_instr2, if_id_instr2, if_id_pc_plus12, fetch_count2;
  logic        if_id_valid2, halted2;

  logic [31:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // behavioural model state
  int          m_pc;
  bit          m_halted;
  logic [31:0] m_count, m_instr, m_pc1;
  bit          m_valid;

  always #5 clk = ~clk;

  assign imem_instr  = mem[imem_addr[9:0]];
  assign imem_instr2 = mem[imem_addr2[9:0]];

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus1  (if_id_pc_plus1),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  instruction_fetch_unit #(.RESET_PC(1023)) dut_top (
    .clk             (clk),
    .rst             (rst2),
    .stall           (1'b0),
    .redirect_valid  (1'b0),
    .redirect_target (10'd0),
    .imem_addr       (imem_addr2),
    .imem_instr      (imem_instr2),
    .if_id_instr     (if_id_instr2),
    .if_id_pc_plus1  (if_id_pc_plus12),
    .if_id_valid     (if_id_valid2),
    .halted          (halted2),
    .fetch_count     (fetch_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Apply one edge's worth of inputs, advance the model by the fetch rules,
  // then compare every output after the edge.
  task automatic cycle(input bit r, input bit s, input bit rv, input int tgt);
    logic [31:0] w;
    rst = r; stall = s; redirect_valid = rv; redirect_target = 10'(tgt);
    w = mem[m_pc];
    if (r) begin
      m_pc = 0; m_halted = 0; m_count = 0; m_instr = NOP; m_pc1 = 0; m_valid = 0;
    end else if (rv) begin
      m_pc = tgt; m_halted = 0; m_instr = NOP; m_valid = 0;
    end else if (s || m_halted) begin
      // nothing moves
    end else if (w == HALT) begin
      m_halted = 1; m_instr = NOP; m_valid = 0;
    end else begin
      m_instr = w; m_pc1 = m_pc + 1; m_valid = 1;
      m_pc = (m_pc + 1) % 1024;
      m_count = m_count + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("imem_addr", imem_addr, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc_plus1", if_id_pc_plus1, m_pc1);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("fetch_count", fetch_count, m_count);
    $display("cyc %0d rst=%0b stall=%0b redir=%0b tgt=%0d | pc=%0d instr=%h pc1=%0d v=%0b halted=%0b cnt=%0d",
             cyc, r, s, rv, tgt, imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid, halted, fetch_count);
  endtask

  initial begin
    int guard;
    rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0; rst2 = 1;
    m_pc = 0; m_halted = 0; m_count = 0; m_instr = NOP; m_pc1 = 0; m_valid = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 + i;
    mem[0] = 32'h214A0005; mem[1] = 32'h21290001;
    mem[2] = 32'h112A0001; mem[3] = 32'h08000001;
    mem[7] = HALT;

    // Reset state
    cycle(1, 0, 0, 0);
    check("reset_pc", imem_addr, 32'd0);
    check("reset_instr", if_id_instr, NOP);
    check("reset_valid", {31'd0, if_id_valid}, 32'd0);

    // Sequential fetch 0..3, IF/ID one cycle behind
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0, 0, 0);
      check("seq_addr", imem_addr, 32'(k));
      check("seq_pc1", if_id_pc_plus1, 32'(k));
      check("seq_instr", if_id_instr, mem[k-1]);
    end
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
    // Halt at 7, stays halted
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_pc", imem_addr, 32'd7);
      check("halt_valid", {31'd0, if_id_valid}, 32'd0);
      check("halt_count", fetch_count, 32'd7);
      cycle(0, 0, 0, 0);
    end
    // Reset while halted
    cycle(1, 0, 0, 0);
    check("rst_halt_pc", imem_addr, 32'd0);
    check("rst_halt_flag", {31'd0, halted}, 32'd0);
    check("rst_halt_count", fetch_count, 32'd0);

    // Stall at pc=2
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 1, 0, 0);
      check("stall_pc", imem_addr, 32'd2);
      check("stall_instr", if_id_instr, 32'h21290001);
      check("stall_count", fetch_count, 32'd2);
    end
    cycle(0, 0, 0, 0);
    check("resume_instr", if_id_instr, 32'h112A0001);
    check("resume_pc", imem_addr, 32'd3);
    // Redirect with stall at pc=3
    cycle(0, 1, 1, 1);
    check("redir_pc", imem_addr, 32'd1);
    check("redir_valid", {31'd0, if_id_valid}, 32'd0);
    check("redir_instr", if_id_instr, NOP);
    // Run to the halt word, then redirect out of HALTED
    guard = 0;
    while (!m_halted && guard < 20) begin
      cycle(0, 0, 0, 0);
      guard++;
    end
    check("reach_halt", {31'd0, halted}, 32'd1);
    cycle(0, 0, 1, 0);
    check("unhalt_flag", {31'd0, halted}, 32'd0);
    check("unhalt_pc", imem_addr, 32'd0);
    cycle(0, 0, 0, 0);
    check("restart_instr", if_id_instr, 32'h214A0005);

    // Randomized traffic
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 31) == 0) ? HALT : $urandom;
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), int'($urandom_range(0, 1023)));
    end

    // PC wrap from 1023 on the second instance
    mem[1023] = 32'h1234_5678;
    mem[0]    = 32'h0BAD_F00D;
    rst2 = 1;
    @(posedge clk); #1;
    check("wrap_reset_pc", imem_addr2, 32'd1023);
    rst2 = 0;
    @(posedge clk); #1;
    check("wrap_pc", imem_addr2, 32'd0);
    check("wrap_pc1", if_id_pc_plus12, 32'd1024);
    check("wrap_valid", {31'd0, if_id_valid2}, 32'd1);
    check("wrap_instr", if_id_instr2, 32'h1234_5678);
    check("wrap_count", fetch_count2, 32'd1);
    $display("wrap pc=%0d pc1=%0d v=%0b halted=%0b", imem_addr2, if_id_pc_plus12, if_id_valid2, halted2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
